// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer
// Description : Circular instruction-pair packet queue between IF and the
//               FIFO->ID register; readygo/allowin handshake, flush, NOP head.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned PTR_W    = $clog2(DEPTH),
    parameter logic [31:0] PC_RESET = 32'h1c00_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        fb_flush,

    input  logic        if_readygo,
    output logic        fb_allowin,
    input  logic [31:0] if_inst0,
    input  logic [31:0] if_inst1,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_pcAdd,
    input  logic [31:0] if_pc_next,
    input  logic [31:0] if_badv,
    input  logic [31:0] if_cookie_out,
    input  logic [6:0]  if_exception,
    input  logic [1:0]  if_excp_flag,
    input  logic [1:0]  if_priv_flag,

    output logic        fifo_readygo,
    input  logic        fifo_allowin,
    output logic [31:0] fifo_inst0,
    output logic [31:0] fifo_inst1,
    output logic [31:0] fifo_pc,
    output logic [31:0] fifo_pcAdd,
    output logic [31:0] fifo_pc_next,
    output logic [31:0] fifo_badv,
    output logic [31:0] fifo_cookie_out,
    output logic [6:0]  fifo_exception,
    output logic [1:0]  fifo_excp_flag,
    output logic [1:0]  fifo_priv_flag,

    output logic        fetch_buf_empty,
    output logic        fetch_buf_full
);

    localparam logic [31:0]    INST_NOP = 32'h0340_0000;
    localparam int unsigned    PKT_W    = 7 * 32 + 7 + 2 + 2;
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [PKT_W-1:0] mem_q [DEPTH];

    logic [PKT_W-1:0] wr_pkt;
    logic [PKT_W-1:0] nop_pkt;
    logic             push;
    logic             pop;

    assign fetch_buf_empty = (count_q == '0);
    assign fetch_buf_full  = (count_q == CNT_FULL);
    // Allowin depends only on registered count: a same-cycle pop never frees a slot early.
    assign fb_allowin      = !fetch_buf_full;
    assign fifo_readygo    = !fetch_buf_empty;

    assign push = if_readygo && fb_allowin;
    assign pop  = fifo_readygo && fifo_allowin;

    assign wr_pkt = {if_inst0, if_inst1, if_pc, if_pcAdd, if_pc_next, if_badv,
                     if_cookie_out, if_exception, if_excp_flag, if_priv_flag};

    assign nop_pkt = {INST_NOP, INST_NOP, PC_RESET, PC_RESET + 32'd4,
                      PC_RESET + 32'd8, PC_RESET, 32'd0, 7'd0, 2'd0, 2'd0};

    assign {fifo_inst0, fifo_inst1, fifo_pc, fifo_pcAdd, fifo_pc_next, fifo_badv,
            fifo_cookie_out, fifo_exception, fifo_excp_flag, fifo_priv_flag}
        = fetch_buf_empty ? nop_pkt : mem_q[head_q];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (fb_flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PTR_W'(1);
            if (pop)  head_d = head_q + PTR_W'(1);
            if (push && !pop)
                count_d = count_q + (PTR_W + 1)'(1);
            else if (pop && !push)
                count_d = count_q - (PTR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately left out of reset and untouched by flush.
    always_ff @(posedge clk) begin
        if (push && !fb_flush)
            mem_q[tail_q] <= wr_pkt;
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_buffer
// Description : Self-checking bench for fetch_buffer: queue model + directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_buffer;

    localparam int unsigned DEPTH    = 8;
    localparam logic [31:0] PC_RST   = 32'h1c00_0000;
    localparam logic [31:0] NOP_INST = 32'h0340_0000;
    localparam int unsigned PKT_W    = 7 * 32 + 7 + 2 + 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        fb_flush = 1'b0;
    logic        if_readygo = 1'b0;
    logic        fb_allowin;
    logic [31:0] if_inst0 = '0, if_inst1 = '0, if_pc = '0, if_pcAdd = '0;
    logic [31:0] if_pc_next = '0, if_badv = '0, if_cookie_out = '0;
    logic [6:0]  if_exception = '0;
    logic [1:0]  if_excp_flag = '0, if_priv_flag = '0;
    logic        fifo_readygo;
    logic        fifo_allowin = 1'b0;
    logic [31:0] fifo_inst0, fifo_inst1, fifo_pc, fifo_pcAdd, fifo_pc_next;
    logic [31:0] fifo_badv, fifo_cookie_out;
    logic [6:0]  fifo_exception;
    logic [1:0]  fifo_excp_flag, fifo_priv_flag;
    logic        fetch_buf_empty, fetch_buf_full;

    int n_cmp = 0;
    int n_err = 0;

    fetch_buffer #(.DEPTH(DEPTH), .PC_RESET(PC_RST)) dut (
        .clk(clk), .rstn(rstn), .fb_flush(fb_flush),
        .if_readygo(if_readygo), .fb_allowin(fb_allowin),
        .if_inst0(if_inst0), .if_inst1(if_inst1), .if_pc(if_pc), .if_pcAdd(if_pcAdd),
        .if_pc_next(if_pc_next), .if_badv(if_badv), .if_cookie_out(if_cookie_out),
        .if_exception(if_exception), .if_excp_flag(if_excp_flag), .if_priv_flag(if_priv_flag),
        .fifo_readygo(fifo_readygo), .fifo_allowin(fifo_allowin),
        .fifo_inst0(fifo_inst0), .fifo_inst1(fifo_inst1), .fifo_pc(fifo_pc),
        .fifo_pcAdd(fifo_pcAdd), .fifo_pc_next(fifo_pc_next), .fifo_badv(fifo_badv),
        .fifo_cookie_out(fifo_cookie_out), .fifo_exception(fifo_exception),
        .fifo_excp_flag(fifo_excp_flag), .fifo_priv_flag(fifo_priv_flag),
        .fetch_buf_empty(fetch_buf_empty), .fetch_buf_full(fetch_buf_full)
    );

    always #5 clk = ~clk;

    logic [PKT_W-1:0] in_pkt, out_pkt, nop_pkt;
    assign in_pkt  = {if_inst0, if_inst1, if_pc, if_pcAdd, if_pc_next, if_badv,
                      if_cookie_out, if_exception, if_excp_flag, if_priv_flag};
    assign out_pkt = {fifo_inst0, fifo_inst1, fifo_pc, fifo_pcAdd, fifo_pc_next, fifo_badv,
                      fifo_cookie_out, fifo_exception, fifo_excp_flag, fifo_priv_flag};
    assign nop_pkt = {NOP_INST, NOP_INST, PC_RST, PC_RST + 32'd4, PC_RST + 32'd8, PC_RST,
                      32'd0, 7'd0, 2'd0, 2'd0};

    // Reference: an ordered queue of packets with capacity DEPTH.
    logic [PKT_W-1:0] mq[$];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mq.delete();
        end else if (fb_flush) begin
            mq.delete();
        end else begin
            automatic bit do_push = if_readygo && (mq.size() < DEPTH);
            automatic bit do_pop  = fifo_allowin && (mq.size() > 0);
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(in_pkt);
        end
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        automatic int sz = mq.size();
        chk("empty",   256'(fetch_buf_empty), 256'(sz == 0));
        chk("full",    256'(fetch_buf_full),  256'(sz == DEPTH));
        chk("allowin", 256'(fb_allowin),      256'(sz != DEPTH));
        chk("readygo", 256'(fifo_readygo),    256'(sz != 0));
        chk("packet",  256'(out_pkt),         256'(sz == 0 ? nop_pkt : mq[0]));
    end

    task automatic set_pkt(input logic [31:0] pc);
        if_pc         = pc;
        if_inst0      = pc ^ 32'hA5A5_0000;
        if_inst1      = ~pc;
        if_pcAdd      = pc + 32'd4;
        if_pc_next    = pc + 32'd8;
        if_badv       = pc + 32'd1;
        if_cookie_out = pc * 32'd3;
        if_exception  = pc[9:3];
        if_excp_flag  = pc[4:3];
        if_priv_flag  = pc[6:5];
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset then idle
        step(); step();
        chk("rst_inst0",   256'(fifo_inst0),      256'(32'h0340_0000));
        chk("rst_empty",   256'(fetch_buf_empty), 256'(1));
        chk("rst_allowin", 256'(fb_allowin),      256'(1));
        chk("rst_readygo", 256'(fifo_readygo),    256'(0));
        rstn = 1'b1;
        step();

        // Three pushes, then drain in order
        for (int i = 0; i < 3; i++) begin
            set_pkt(32'h1c00_0000 + 32'(8 * i));
            if_readygo = 1'b1;
            step();
        end
        if_readygo   = 1'b0;
        fifo_allowin = 1'b1;
        chk("order_pc0", 256'(fifo_pc), 256'(32'h1c00_0000));
        step();
        chk("order_pc1", 256'(fifo_pc), 256'(32'h1c00_0008));
        step();
        chk("order_pc2", 256'(fifo_pc), 256'(32'h1c00_0010));
        step();
        chk("drain_empty", 256'(fetch_buf_empty), 256'(1));
        chk("drain_nop",   256'(fifo_inst0),      256'(32'h0340_0000));
        fifo_allowin = 1'b0;

        // Fill to full; ninth push refused
        if_readygo = 1'b1;
        for (int i = 0; i < 9; i++) begin
            set_pkt(32'h1c00_1000 + 32'(8 * i));
            step();
            if (i == 7) begin
                chk("full_flag",    256'(fetch_buf_full), 256'(1));
                chk("full_allowin", 256'(fb_allowin),     256'(0));
            end
        end
        chk("refused_model_cnt", 256'(mq.size()),      256'(8));
        chk("refused_full",      256'(fetch_buf_full), 256'(1));
        if_readygo   = 1'b0;
        fifo_allowin = 1'b1;
        step();
        chk("after_pop_allowin", 256'(fb_allowin), 256'(1));
        chk("after_pop_head",    256'(fifo_pc),    256'(32'h1c00_1008));
        repeat (7) step();
        fifo_allowin = 1'b0;

        // Steady stream at count 2 with pointer wrap
        if_readygo = 1'b1;
        for (int k = 0; k < 2; k++) begin
            set_pkt(32'h1c00_2000 + 32'(8 * k));
            step();
        end
        fifo_allowin = 1'b1;
        for (int k = 2; k < 22; k++) begin
            set_pkt(32'h1c00_2000 + 32'(8 * k));
            step();
            chk("stream_head", 256'(fifo_pc),   256'(32'h1c00_2000 + 32'(8 * (k - 1))));
            chk("stream_cnt",  256'(mq.size()), 256'(2));
        end
        fifo_allowin = 1'b0;

        // Build count 5, then flush with push+pop in the same cycle
        for (int k = 0; k < 3; k++) begin
            set_pkt(32'h1c00_3000 + 32'(8 * k));
            step();
        end
        chk("pre_flush_cnt", 256'(mq.size()), 256'(5));
        set_pkt(32'h1c0f_0000);
        fb_flush     = 1'b1;
        fifo_allowin = 1'b1;
        step();
        fb_flush     = 1'b0;
        fifo_allowin = 1'b0;
        if_readygo   = 1'b0;
        chk("flush_empty",   256'(fetch_buf_empty), 256'(1));
        chk("flush_allowin", 256'(fb_allowin),      256'(1));
        chk("flush_nop",     256'(fifo_inst0),      256'(32'h0340_0000));
        set_pkt(32'h1c00_4000);
        if_readygo = 1'b1;
        step();
        chk("post_flush_head", 256'(fifo_pc), 256'(32'h1c00_4000));

        // Count 4 then asynchronous reset between edges
        for (int k = 1; k < 4; k++) begin
            set_pkt(32'h1c00_4000 + 32'(8 * k));
            step();
        end
        if_readygo = 1'b0;
        chk("pre_rst_cnt", 256'(mq.size()), 256'(4));
        #1 rstn = 1'b0;
        #1;
        chk("async_rst_empty", 256'(fetch_buf_empty), 256'(1));
        chk("async_rst_inst0", 256'(fifo_inst0),      256'(32'h0340_0000));
        step();
        rstn = 1'b1;
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction fetch buffer between the instruction-fetch stage and the FIFO→ID pipeline register. It queues fetched instruction-pair packets in a circular buffer and presents the oldest packet to the downstream register under a readygo/allowin handshake. It decouples fetch from decode and exports empty/full status to downstream. On flush it discards all queued packets.

## Interface
Parameters:
- DEPTH, 8, number of packet entries; power of two, ≥2
- PTR_W, $clog2(DEPTH), pointer width; count width is PTR_W+1

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous, active-low reset
- fb_flush  in  1  discard all entries (branch mispredict / exception redirect)
- if_readygo  in  1  fetch stage presents a valid packet
- fb_allowin  out  1  buffer accepts a push this cycle
- if_inst0, if_inst1  in  32 each  instruction pair
- if_pc, if_pcAdd, if_pc_next, if_badv, if_cookie_out  in  32 each  packet PC fields, bad address, predictor cookie
- if_exception  in  7  exception code
- if_excp_flag, if_priv_flag  in  2 each  exception and privilege flags
- fifo_readygo  out  1  head packet valid
- fifo_allowin  in  1  downstream register accepts head this cycle
- fifo_inst0 … fifo_priv_flag  out  same widths as if_*  head packet fields
- fetch_buf_empty  out  1  count == 0
- fetch_buf_full  out  1  count == DEPTH

## Operation
- Packet = all if_* fields; one entry per packet; the 32-bit fields plus exception and flags are stored together.
- State: head, tail (PTR_W bits each, wrap modulo DEPTH), count (PTR_W+1 bits).
- push = if_readygo && fb_allowin; fb_allowin = !fetch_buf_full, from registered count only. A push while full is refused even if a pop occurs in the same cycle.
- pop = fifo_readygo && fifo_allowin; fifo_readygo = !fetch_buf_empty.
- Push writes entry[tail] and increments tail. Pop increments head. Count update: +1 on push only, −1 on pop only, unchanged on both or on neither.
- Outputs fifo_* are combinational from entry[head]. When empty, they force a NOP packet: inst0 = inst1 = INST_NOP (0x03400000), pc = PC_RESET, pcAdd = PC_RESET+4, pc_next = PC_RESET+8, badv = PC_RESET, cookie = 0, exception = 0, flags = 0.
- No bypass: a packet pushed into an empty buffer is not visible at the outputs in the same cycle.
- fb_flush has priority over everything. On the next edge head = tail = count = 0. Push and pop in the flush cycle are discarded. Storage contents are left unchanged.

## Timing
- Reset (async assert, sync release): head = tail = count = 0. Outputs: fetch_buf_empty = 1, fetch_buf_full = 0, fb_allowin = 1, fifo_readygo = 0, fifo_* = NOP packet. Storage is not reset.
- Push-to-output latency: 1 cycle. A packet pushed at edge N appears at fifo_* after edge N if it is then at the head.
- Throughput: 1 push and 1 pop per cycle sustained when 0 < count < DEPTH.
- Full: fb_allowin = 0 for the whole cycle. A pop that cycle frees one entry, and fb_allowin = 1 the next cycle.
- Empty: fifo_readygo = 0 and fifo_allowin is ignored. A push that cycle gives count = 1 next cycle.
- Wrap-around: pointers roll from DEPTH−1 to 0 with no bubble.
- Flush during full or empty: the buffer is empty next cycle, fb_allowin = 1, and outputs are the NOP packet.
- Reset asserted mid-operation: all state clears immediately, with no dependence on clk.

## Test plan
- Reset then idle: fetch_buf_empty = 1, fifo_readygo = 0, fifo_inst0 = 0x03400000, fb_allowin = 1.
- Push 3 packets with pc 0x1c000000/0x1c000008/0x1c000010 and fifo_allowin = 0, then hold fifo_allowin = 1: outputs pop pc 0x1c000000, then 0x1c000008, then 0x1c000010 on consecutive cycles, then return to NOP with empty = 1.
- Push 8 with no pop: fetch_buf_full = 1 and fb_allowin = 0. A 9th if_readygo is refused and count stays 8. One pop gives fb_allowin = 1 next cycle.
- Steady stream with push and pop every cycle for 20 cycles starting at count = 2: count stays 2, head/tail wrap past 7→0, and output order matches input order.
- Assert fb_flush with count = 5 and push+pop asserted in the same cycle: next cycle count = 0, empty = 1, and the flushed-cycle packet never appears at the outputs.
- Deassert rstn asynchronously mid-stream at count = 4: empty = 1 and fifo_inst0 = 0x03400000 before the next clk edge.
